// File: rtl/inst_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_fetch_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int PC_STEP    = 4;
    localparam int FETCH_ST_W = 2;

    // sll $0,$0,0 encodes as all zeros and doubles as the filler NOP
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD        = '0;
    localparam logic [WORD_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [FETCH_ST_W-1:0] {
        FETCH_ST_IDLE  = 2'd0,
        FETCH_ST_REQ   = 2'd1,
        FETCH_ST_DRAIN = 2'd2
    } fetch_st_e;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, inst} pairs; flush empties it in one cycle.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none; the caller reserves a slot before requesting, so push never sees full.
module inst_fetch_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [DW-1:0] head_o,
    output logic [CW-1:0] count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage write; stale contents are harmless because count gates every read
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); flush wins over push/pop
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, issues one imem read at a time, buffers replies, feeds the decoder.
// Latency: 1-cycle memory -> first inst_valid 3 cycles after reset release, then 1 inst/cycle.
// Backpressure: stall freezes the output register; fetch stops once every FIFO slot is reserved.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int             W        = WORD_WIDTH,
    parameter int             DEPTH    = 2,
    parameter logic [W-1:0]   RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect_en,
    input  logic [W-1:0] redirect_addr,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc,
    output logic         inst_valid
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_st_e     state_q, state_d;
    logic [W-1:0]  pc_q, pc_d;
    logic [W-1:0]  drain_addr_q, drain_addr_d;
    logic [W-1:0]  inst_q, inst_pc_q;
    logic          inst_valid_q;

    logic [2*W-1:0] head;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_after_push;
    logic           push, pop;

    // A reply is kept only if it lands in REQ and no redirect squashes it
    assign push = (state_q == FETCH_ST_REQ) && imem_ready && !redirect_en;
    assign pop  = !redirect_en && !stall && (count != '0);
    assign count_after_push = count + CW'(1) - CW'(pop);

    inst_fetch_fifo #(.DW(2 * W), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i ({pc_q, imem_rdata}),
        .pop_i      (pop),
        .flush_i    (redirect_en),
        .head_o     (head),
        .count_o    (count)
    );

    // Next state, PC and the address held while draining a squashed request
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        case (state_q)
            FETCH_ST_IDLE: begin
                if (count < DEPTH_C && !redirect_en) state_d = FETCH_ST_REQ;
            end
            FETCH_ST_REQ: begin
                if (redirect_en) begin
                    if (imem_ready) begin
                        state_d = FETCH_ST_IDLE;
                    end else begin
                        state_d      = FETCH_ST_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_q + W'(PC_STEP);
                    if (count_after_push >= DEPTH_C) state_d = FETCH_ST_IDLE;
                end
            end
            FETCH_ST_DRAIN: begin
                if (imem_ready) state_d = FETCH_ST_IDLE;
            end
            default: state_d = FETCH_ST_IDLE;
        endcase
        if (redirect_en) pc_d = redirect_addr & ~W'(3);
    end

    // FSM, PC and drain-address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_ST_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Decoder-facing register: redirect flushes, stall holds, otherwise pop or emit a NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q       <= W'(ZERO_WORD);
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else if (redirect_en) begin
            inst_q       <= W'(ZERO_WORD);
            inst_valid_q <= 1'b0;
        end else if (!stall) begin
            if (count != '0) begin
                inst_q       <= head[W-1:0];
                inst_pc_q    <= head[2*W-1:W];
                inst_valid_q <= 1'b1;
            end else begin
                inst_q       <= W'(ZERO_WORD);
                inst_valid_q <= 1'b0;
            end
        end
    end

    assign imem_req   = (state_q == FETCH_ST_REQ) || (state_q == FETCH_ST_DRAIN);
    assign imem_addr  = (state_q == FETCH_ST_DRAIN) ? drain_addr_q : pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural memory returning word index addr>>2.
// Latency: memory answers after mem_lat cycles of a held request (or never while mem_block).
// Backpressure: stall and redirect driven from the scenario tasks.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_en, imem_req, imem_ready, inst_valid;
    logic [31:0] redirect_addr, imem_addr, imem_rdata, inst, inst_pc;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int exp_idx = 0;
    int mem_lat = 1;
    int wait_cnt = 0;
    logic mem_block = 1'b0;

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_en   (redirect_en),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid)
    );

    always #5 clk = ~clk;

    // Memory model: evaluated just after each falling edge, so it sees settled requests
    initial begin
        imem_ready = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (imem_req && !mem_block) begin
                if (wait_cnt >= mem_lat - 1) begin
                    imem_ready = 1'b1;
                    imem_rdata = imem_addr >> 2;
                    wait_cnt   = 0;
                end else begin
                    imem_ready = 1'b0;
                    wait_cnt   = wait_cnt + 1;
                end
            end else begin
                imem_ready = 1'b0;
                if (!imem_req) wait_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_stream();
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_addr = '0;
        tick(); tick();
        cmp_cnt++; if (inst !== 32'h0) begin err_cnt++; $display("FAIL rst_inst got %h want %h", inst, 32'h0); end
        cmp_cnt++; if (inst_pc !== 32'h0) begin err_cnt++; $display("FAIL rst_inst_pc got %h want %h", inst_pc, 32'h0); end
        cmp_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got %b want 0", inst_valid); end
        cmp_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL rst_req got %b want 0", imem_req); end
        cmp_cnt++; if (imem_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_addr got %h want %h", imem_addr, 32'h0); end
        rst = 1'b0;
        tick();
        cmp_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin err_cnt++; $display("FAIL first_req got req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'h0); end
        tick();
        cmp_cnt++; if (inst_valid !== 1'b0 || imem_addr !== 32'h4) begin err_cnt++; $display("FAIL fill_cycle got valid=%b addr=%h want 0 %h", inst_valid, imem_addr, 32'h4); end
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            cmp_cnt++;
            if (inst_valid !== 1'b1 || inst !== 32'(i) || inst_pc !== 32'(4 * i)) begin
                err_cnt++;
                $display("FAIL stream[%0d] got v=%b inst=%h pc=%h want 1 %h %h", i, inst_valid, inst, inst_pc, 32'(i), 32'(4 * i));
            end
        end
        exp_idx = 6;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp_cnt++;
            if (inst !== 32'h5 || inst_pc !== 32'h14 || inst_valid !== 1'b1) begin
                err_cnt++;
                $display("FAIL stall_hold[%0d] got inst=%h pc=%h v=%b want %h %h 1", i, inst, inst_pc, inst_valid, 32'h5, 32'h14);
            end
            cmp_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL stall_full_req[%0d] got %b want 0", i, imem_req); end
        end
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            cmp_cnt++;
            if (inst_valid !== 1'b1 || inst !== 32'(exp_idx) || inst_pc !== 32'(4 * exp_idx)) begin
                err_cnt++;
                $display("FAIL stall_release[%0d] got v=%b inst=%h pc=%h want 1 %h %h", i, inst_valid, inst, inst_pc, 32'(exp_idx), 32'(4 * exp_idx));
            end
            exp_idx++;
        end
    endtask

    task automatic test_slow_mem();
        int seen = 0;
        int filler = 0;
        mem_lat = 3;
        for (int cyc = 0; cyc < 120 && seen < 6; cyc++) begin
            tick();
            if (inst_valid) begin
                cmp_cnt++;
                if (inst !== 32'(exp_idx) || inst_pc !== 32'(4 * exp_idx)) begin
                    err_cnt++;
                    $display("FAIL slow_word[%0d] got inst=%h pc=%h want %h %h", seen, inst, inst_pc, 32'(exp_idx), 32'(4 * exp_idx));
                end
                exp_idx++;
                seen++;
            end else begin
                filler++;
            end
        end
        cmp_cnt++; if (seen != 6) begin err_cnt++; $display("FAIL slow_count got %0d words want 6", seen); end
        cmp_cnt++; if (filler < 1) begin err_cnt++; $display("FAIL slow_filler got %0d fillers want >=1", filler); end
        mem_lat = 1;
    endtask

    task automatic test_redirect_drain();
        rst = 1'b1; mem_block = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        cmp_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin err_cnt++; $display("FAIL drain_pre got req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'h0); end
        redirect_en = 1'b1; redirect_addr = 32'h100;
        tick();
        cmp_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin err_cnt++; $display("FAIL drain_hold got req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'h0); end
        cmp_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_flush_valid got %b want 0", inst_valid); end
        redirect_en = 1'b0; mem_block = 1'b0;
        tick();
        cmp_cnt++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_done got req=%b v=%b want 0 0", imem_req, inst_valid); end
        tick();
        cmp_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin err_cnt++; $display("FAIL drain_next got req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'h100); end
        tick(); tick();
        cmp_cnt++; if (inst_valid !== 1'b1 || inst !== 32'h40 || inst_pc !== 32'h100) begin err_cnt++; $display("FAIL drain_inst got v=%b inst=%h pc=%h want 1 %h %h", inst_valid, inst, inst_pc, 32'h40, 32'h100); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect_en = 1'b1; redirect_addr = 32'h200;
        tick();
        cmp_cnt++; if (inst !== 32'h0 || inst_valid !== 1'b0) begin err_cnt++; $display("FAIL rs_out got inst=%h v=%b want %h 0", inst, inst_valid, 32'h0); end
        cmp_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL rs_req got %b want 0", imem_req); end
        stall = 1'b0; redirect_en = 1'b0;
        tick();
        cmp_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL rs_fifo_empty got v=%b want 0", inst_valid); end
        cmp_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin err_cnt++; $display("FAIL rs_next got req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'h200); end
        tick(); tick();
        cmp_cnt++; if (inst_valid !== 1'b1 || inst !== 32'h80 || inst_pc !== 32'h200) begin err_cnt++; $display("FAIL rs_inst got v=%b inst=%h pc=%h want 1 %h %h", inst_valid, inst, inst_pc, 32'h80, 32'h200); end
    endtask

    task automatic test_align_wrap_reset();
        redirect_en = 1'b1; redirect_addr = 32'h103;
        tick();
        cmp_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL align_idle got req=%b want 0", imem_req); end
        redirect_en = 1'b0;
        tick();
        cmp_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin err_cnt++; $display("FAIL align_addr got req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'h100); end
        redirect_en = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        tick();
        redirect_en = 1'b0;
        tick();
        cmp_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL wrap_pre got req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'hFFFF_FFFC); end
        tick();
        cmp_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin err_cnt++; $display("FAIL wrap_addr got req=%b addr=%h want 1 %h", imem_req, imem_addr, 32'h0); end
        tick();
        cmp_cnt++; if (inst_valid !== 1'b1 || inst !== 32'h3FFF_FFFF || inst_pc !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL wrap_inst got v=%b inst=%h pc=%h want 1 %h %h", inst_valid, inst, inst_pc, 32'h3FFF_FFFF, 32'hFFFF_FFFC); end
        rst = 1'b1;
        tick();
        cmp_cnt++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin err_cnt++; $display("FAIL midreq_rst got req=%b addr=%h want 0 %h", imem_req, imem_addr, 32'h0); end
        cmp_cnt++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin err_cnt++; $display("FAIL midreq_out got v=%b inst=%h pc=%h want 0 0 0", inst_valid, inst, inst_pc); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset_stream();
        test_stall();
        test_slow_mem();
        test_redirect_drain();
        test_redirect_stall();
        test_align_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
